// File: rtl/parity_frame_rx.sv
// parity_frame_rx: serial frame receiver.
// Frame on the line: start bit (1), DATA_W data bits MSB first, odd-parity bit.
// in_bit is sampled only on in_valid=1 cycles, so gaps may appear anywhere.
//
// The decoded frame is captured at the edge that samples the parity bit.
// It is presented on the output register one edge later.
//
// Output handshake (valid/ready): a frame is transferred on any clock edge
// where out_valid=1 and out_ready=1. While out_valid=1, the signals data_out
// and par_err stay stable until that transfer happens. out_valid never drops
// without a transfer.
//
// Optional feature: define PARITY_FRAME_RX_ERRCNT_EN to build the saturating
// parity-error counter on err_cnt. Without it, err_cnt is tied to zero.
module parity_frame_rx #(
  parameter int DATA_W = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic              in_bit,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] data_out,
  output logic              par_err,
  output logic              overrun,
  output logic [7:0]        err_cnt
);

  // Counter only needs to index 0..DATA_W-1 within the data phase.
  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    PAR  = 2'd2
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  cnt_nxt;
  logic [DATA_W-1:0] sr;
  logic [DATA_W-1:0] sr_nxt;
  logic [DATA_W:0]   sh_ext;

  // Completed-frame strobe and its parity verdict, decoded in the PAR state.
  logic              frame_done;
  logic              frame_perr;

  // Capture stage between the deserialiser and the output register.
  logic              done_q;
  logic [DATA_W-1:0] data_q;
  logic              perr_q;

  // Output register control.
  logic              load;
  logic              drop;

  // FSM state, bit counter and shift register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      sr    <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      sr    <= sr_nxt;
    end
  end

  // Next-state logic: start detection, MSB-first shifting, and the parity check.
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    sr_nxt     = sr;
    sh_ext     = {sr, in_bit};
    frame_done = 1'b0;
    frame_perr = 1'b0;
    case (state)
      IDLE: begin
        // A 0 on the line is idle; a 1 is a start bit.
        if (in_valid && in_bit) begin
          state_nxt = DATA;
          cnt_nxt   = '0;
        end
      end
      DATA: begin
        if (in_valid) begin
          sr_nxt = sh_ext[DATA_W-1:0];
          if (cnt == LAST_BIT) begin
            state_nxt = PAR;
          end else begin
            cnt_nxt = cnt + 1'b1;
          end
        end
      end
      PAR: begin
        if (in_valid) begin
          // Good frame: data ones plus parity bit is odd.
          frame_done = 1'b1;
          frame_perr = ~((^sr) ^ in_bit);
          state_nxt  = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Capture the completed frame at the parity-sampling edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      done_q <= 1'b0;
      data_q <= '0;
      perr_q <= 1'b0;
    end else begin
      done_q <= frame_done;
      if (frame_done) begin
        data_q <= sr;
        perr_q <= frame_perr;
      end
    end
  end

  // A captured frame loads whenever the output slot is empty or being emptied.
  // It is dropped only when the held frame is not being taken this cycle.
  assign load = done_q && (!out_valid || out_ready);
  assign drop = done_q && out_valid && !out_ready;

  // Output register with hold-until-accepted semantics and an overrun pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      data_out  <= '0;
      par_err   <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      overrun <= drop;
      if (load) begin
        out_valid <= 1'b1;
        data_out  <= data_q;
        par_err   <= perr_q;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

`ifdef PARITY_FRAME_RX_ERRCNT_EN
  // Count loaded frames that failed parity. Saturate at 255.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_cnt <= 8'd0;
    end else if (load && perr_q && (err_cnt != 8'hFF)) begin
      err_cnt <= err_cnt + 8'd1;
    end
  end
`else
  assign err_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_parity_frame_rx.sv
// Directed bench for parity_frame_rx (DATA_W=3).
// Inputs are driven on the falling edge and outputs are sampled on the falling edge.
module tb_parity_frame_rx;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_bit = 1'b0;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [2:0] data_out;
  logic       par_err;
  logic       overrun;
  logic [7:0] err_cnt;

  int errors = 0;
  int checks = 0;

  parity_frame_rx #(.DATA_W(3)) dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_bit(in_bit),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .data_out(data_out),
    .par_err(par_err),
    .overrun(overrun),
    .err_cnt(err_cnt)
  );

  // Clock generation.
  always #5 clk = ~clk;

  // One valid bit on the line. It is sampled by the next rising edge.
  task automatic drive_bit(input logic b);
    @(negedge clk);
    in_valid = 1'b1;
    in_bit   = b;
  endtask

  // One cycle with no valid bit.
  task automatic idle_cycle();
    @(negedge clk);
    in_valid = 1'b0;
    in_bit   = 1'b0;
  endtask

  // Five-bit frame, first bit in f[4], with gap idle cycles after each bit.
  task automatic send_frame(input logic [4:0] f, input int gap);
    for (int i = 4; i >= 0; i--) begin
      drive_bit(f[i]);
      repeat (gap) idle_cycle();
    end
  endtask

  // Reset values, with rst held against an active start bit.
  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b1; in_bit = 1'b1; out_ready = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b want 0", out_valid); end
    checks++; if (data_out !== 3'b000) begin errors++; $display("FAIL rst_data: got %b want 000", data_out); end
    checks++; if (par_err !== 1'b0) begin errors++; $display("FAIL rst_parerr: got %b want 0", par_err); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL rst_overrun: got %b want 0", overrun); end
    checks++; if (err_cnt !== 8'd0) begin errors++; $display("FAIL rst_errcnt: got %0d want 0", err_cnt); end
    rst = 1'b0; in_valid = 1'b0; in_bit = 1'b0;
  endtask

  // Good frame 1,1,0,1,1 -> 101, no parity error. Checks latency and acceptance.
  task automatic test_good();
    send_frame(5'b11011, 0);
    idle_cycle();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL good_latency: got %b want 0", out_valid); end
    idle_cycle();
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL good_valid: got %b want 1", out_valid); end
    checks++; if (data_out !== 3'b101) begin errors++; $display("FAIL good_data: got %b want 101", data_out); end
    checks++; if (par_err !== 1'b0) begin errors++; $display("FAIL good_parerr: got %b want 0", par_err); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL good_overrun: got %b want 0", overrun); end
    idle_cycle();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL good_accept: got %b want 0", out_valid); end
    checks++; if (data_out !== 3'b101) begin errors++; $display("FAIL good_hold_data: got %b want 101", data_out); end
  endtask

  // Bad frame 1,1,0,1,0 -> 101 with a parity error.
  task automatic test_bad_parity();
    send_frame(5'b11010, 0);
    idle_cycle();
    idle_cycle();
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bad_valid: got %b want 1", out_valid); end
    checks++; if (data_out !== 3'b101) begin errors++; $display("FAIL bad_data: got %b want 101", data_out); end
    checks++; if (par_err !== 1'b1) begin errors++; $display("FAIL bad_parerr: got %b want 1", par_err); end
`ifdef PARITY_FRAME_RX_ERRCNT_EN
    checks++; if (err_cnt !== 8'd1) begin errors++; $display("FAIL bad_errcnt: got %0d want 1", err_cnt); end
`else
    checks++; if (err_cnt !== 8'd0) begin errors++; $display("FAIL bad_errcnt: got %0d want 0", err_cnt); end
`endif
  endtask

  // Frame 1,0,0,0,1 with two idle cycles after every bit -> 000, good.
  task automatic test_gaps();
    send_frame(5'b10001, 2);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL gap_valid: got %b want 1", out_valid); end
    checks++; if (data_out !== 3'b000) begin errors++; $display("FAIL gap_data: got %b want 000", data_out); end
    checks++; if (par_err !== 1'b0) begin errors++; $display("FAIL gap_parerr: got %b want 0", par_err); end
    idle_cycle();
  endtask

  // Two good frames back to back while the consumer stalls.
  task automatic test_back_to_back_overrun();
    out_ready = 1'b0;
    send_frame(5'b11011, 0);
    send_frame(5'b10100, 0);
    idle_cycle();
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL ovr_early: got %b want 0", overrun); end
    checks++; if (data_out !== 3'b101) begin errors++; $display("FAIL ovr_first_data: got %b want 101", data_out); end
    idle_cycle();
    checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_pulse: got %b want 1", overrun); end
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL ovr_valid: got %b want 1", out_valid); end
    checks++; if (data_out !== 3'b101) begin errors++; $display("FAIL ovr_held_data: got %b want 101", data_out); end
    checks++; if (par_err !== 1'b0) begin errors++; $display("FAIL ovr_held_parerr: got %b want 0", par_err); end
    idle_cycle();
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL ovr_one_cycle: got %b want 0", overrun); end
    out_ready = 1'b1;
    idle_cycle();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL ovr_accept: got %b want 0", out_valid); end
    checks++; if (data_out !== 3'b101) begin errors++; $display("FAIL ovr_after_data: got %b want 101", data_out); end
  endtask

  // A new frame loads directly in the same cycle that the held frame is accepted.
  task automatic test_direct_load();
    out_ready = 1'b0;
    send_frame(5'b11011, 0);
    idle_cycle();
    idle_cycle();
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL dl_held_valid: got %b want 1", out_valid); end
    send_frame(5'b10111, 0);
    idle_cycle();
    out_ready = 1'b1;
    idle_cycle();
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL dl_valid: got %b want 1", out_valid); end
    checks++; if (data_out !== 3'b011) begin errors++; $display("FAIL dl_data: got %b want 011", data_out); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL dl_overrun: got %b want 0", overrun); end
    idle_cycle();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL dl_drop: got %b want 0", out_valid); end
  endtask

  // Reset mid-frame, then a clean frame 1,0,1,1,1 -> 011, good.
  task automatic test_abort();
    drive_bit(1'b1);
    drive_bit(1'b1);
    drive_bit(1'b0);
    @(negedge clk);
    in_valid = 1'b0; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++; if (data_out !== 3'b000) begin errors++; $display("FAIL abort_rst_data: got %b want 000", data_out); end
    checks++; if (err_cnt !== 8'd0) begin errors++; $display("FAIL abort_rst_errcnt: got %0d want 0", err_cnt); end
    repeat (3) idle_cycle();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL abort_no_output: got %b want 0", out_valid); end
    send_frame(5'b10111, 0);
    idle_cycle();
    idle_cycle();
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL abort_valid: got %b want 1", out_valid); end
    checks++; if (data_out !== 3'b011) begin errors++; $display("FAIL abort_data: got %b want 011", data_out); end
    checks++; if (par_err !== 1'b0) begin errors++; $display("FAIL abort_parerr: got %b want 0", par_err); end
    idle_cycle();
  endtask

  // Saturation of the error counter over 260 bad frames.
  task automatic test_err_saturation();
    logic [7:0] exp10;
    logic [7:0] exp_sat;
`ifdef PARITY_FRAME_RX_ERRCNT_EN
    exp10 = 8'd10; exp_sat = 8'd255;
`else
    exp10 = 8'd0; exp_sat = 8'd0;
`endif
    out_ready = 1'b1;
    repeat (10) send_frame(5'b11010, 0);
    idle_cycle();
    idle_cycle();
    checks++; if (err_cnt !== exp10) begin errors++; $display("FAIL cnt_10: got %0d want %0d", err_cnt, exp10); end
    repeat (250) send_frame(5'b11010, 0);
    idle_cycle();
    idle_cycle();
    checks++; if (err_cnt !== exp_sat) begin errors++; $display("FAIL cnt_260: got %0d want %0d", err_cnt, exp_sat); end
    checks++; if (par_err !== 1'b1) begin errors++; $display("FAIL cnt_parerr: got %b want 1", par_err); end
    send_frame(5'b11010, 0);
    idle_cycle();
    idle_cycle();
    checks++; if (err_cnt !== exp_sat) begin errors++; $display("FAIL cnt_hold: got %0d want %0d", err_cnt, exp_sat); end
  endtask

  // Test sequence and final report.
  initial begin
    test_reset();
    test_good();
    test_bad_parity();
    test_gaps();
    test_back_to_back_overrun();
    test_direct_load();
    test_abort();
    test_err_saturation();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
